// File: rtl/multi_packet_storage.sv
// Multi-channel Ethernet packet store: one packet FIFO per receive channel, drained as a single
// show-ahead byte stream with whole-packet round-robin arbitration and an optional channel tag byte.
module multi_packet_storage #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 64,
  parameter int TAG_MODE = 1,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        wr_en,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic [NUM_CH-1:0]        wr_last,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        drop,
  input  logic                     r_en,
  output logic [DATA_W-1:0]        r_data,
  output logic                     r_last,
  output logic [CH_W-1:0]          r_chan,
  output logic                     pkt_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [PW-1:0] P_CAP = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, TAG = 2'd1, DATA = 2'd2} state_t;

  logic [DATA_W:0] mem [NUM_CH][DEPTH];
  logic [PW-1:0]   wptr [NUM_CH];
  logic [PW-1:0]   cptr [NUM_CH];
  logic [PW-1:0]   rptr [NUM_CH];
  logic [PW-1:0]   wptr_n [NUM_CH];
  logic [PW-1:0]   cptr_n [NUM_CH];
  logic [PW-1:0]   rptr_n [NUM_CH];
  logic [PW-1:0]   pkt_cnt [NUM_CH];
  logic [PW-1:0]   pkt_cnt_n [NUM_CH];
  logic [NUM_CH-1:0] discard, discard_n, at_cap, accept, ovf, commit, pop, last_pop, full_n;

  state_t          state;
  logic [CH_W-1:0] sel, rr_ptr, hit_ch, scan_ch, rd_ch;
  logic            hit;
  int              scan_idx;
  logic [AW-1:0]   rd_addr;
  logic [DATA_W:0] rd_word;

  // Per-channel write acceptance, overflow detection and next pointer/counter values.
  // Capacity is DEPTH-1 so that wptr+1 never lands on rptr.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i]      = (state == DATA) && r_en && (sel == CH_W'(i));
      last_pop[i] = pop[i] && r_last;
      at_cap[i]   = ((wptr[i] - rptr[i]) == P_CAP);
      accept[i]   = wr_en[i] && !discard[i] && !at_cap[i];
      ovf[i]      = wr_en[i] && !discard[i] && at_cap[i];
      commit[i]   = accept[i] && wr_last[i];
      wptr_n[i]   = ovf[i] ? cptr[i] : (accept[i] ? wptr[i] + P_ONE : wptr[i]);
      cptr_n[i]   = commit[i] ? wptr[i] + P_ONE : cptr[i];
      rptr_n[i]   = pop[i] ? rptr[i] + P_ONE : rptr[i];
      case ({commit[i], last_pop[i]})
        2'b10:   pkt_cnt_n[i] = pkt_cnt[i] + P_ONE;
        2'b01:   pkt_cnt_n[i] = pkt_cnt[i] - P_ONE;
        default: pkt_cnt_n[i] = pkt_cnt[i];
      endcase
      discard_n[i] = discard[i] ? !(wr_en[i] && wr_last[i]) : (ovf[i] && !wr_last[i]);
      full_n[i]    = ((wptr_n[i] - rptr_n[i]) == P_CAP);
    end
  end

  // Channel pointer, counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr[i]    <= '0;
        cptr[i]    <= '0;
        rptr[i]    <= '0;
        pkt_cnt[i] <= '0;
      end
      discard <= '0;
      full    <= '0;
      drop    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr[i]    <= wptr_n[i];
        cptr[i]    <= cptr_n[i];
        rptr[i]    <= rptr_n[i];
        pkt_cnt[i] <= pkt_cnt_n[i];
      end
      discard <= discard_n;
      full    <= full_n;
      drop    <= ovf;
    end
  end

  // Packet storage: data byte plus last flag; contents need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept[i]) begin
        mem[i][wptr[i][AW-1:0]] <= {wr_last[i], wr_data[i*DATA_W +: DATA_W]};
      end
    end
  end

  // Round-robin scan from rr_ptr; the lowest offset with a committed packet wins.
  always_comb begin
    hit      = 1'b0;
    hit_ch   = '0;
    scan_idx = 0;
    scan_ch  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_CH;
      scan_ch  = CH_W'(scan_idx);
      if (pkt_cnt[scan_ch] != '0) begin
        hit    = 1'b1;
        hit_ch = scan_ch;
      end else begin
        hit    = hit;
        hit_ch = hit_ch;
      end
    end
  end

  // Head word after this cycle's pop, so the registered output stays show-ahead.
  always_comb begin
    rd_ch   = (state == IDLE) ? hit_ch : sel;
    rd_addr = rptr_n[rd_ch][AW-1:0];
    rd_word = mem[rd_ch][rd_addr];
  end

  // Arbiter FSM with registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      rr_ptr    <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_chan    <= '0;
      pkt_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            sel       <= hit_ch;
            r_chan    <= hit_ch;
            pkt_ready <= 1'b1;
            if (TAG_MODE != 0) begin
              state  <= TAG;
              r_data <= DATA_W'(hit_ch);
              r_last <= 1'b0;
            end else begin
              state  <= DATA;
              r_data <= rd_word[DATA_W-1:0];
              r_last <= rd_word[DATA_W];
            end
          end
        end
        TAG: begin
          if (r_en) begin
            state  <= DATA;
            r_data <= rd_word[DATA_W-1:0];
            r_last <= rd_word[DATA_W];
          end
        end
        DATA: begin
          if (r_en) begin
            if (r_last) begin
              state     <= IDLE;
              pkt_ready <= 1'b0;
              r_data    <= '0;
              r_last    <= 1'b0;
              rr_ptr    <= (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
            end else begin
              r_data <= rd_word[DATA_W-1:0];
              r_last <= rd_word[DATA_W];
            end
          end
        end
        default: begin
          state     <= IDLE;
          pkt_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_packet_storage.sv
// Directed self-checking bench for multi_packet_storage (4 channels, DEPTH=8, tag bytes on).
module tb_multi_packet_storage;

  localparam int NC  = 4;
  localparam int DW  = 8;
  localparam int DEP = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   wr_en, wr_last;
  logic [NC*DW-1:0] wr_data;
  logic            r_en;
  logic [NC-1:0]   full, drop;
  logic [DW-1:0]   r_data;
  logic            r_last;
  logic [1:0]      r_chan;
  logic            pkt_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  logic [1:0]    got_c[$];

  multi_packet_storage #(.NUM_CH(NC), .DATA_W(DW), .DEPTH(DEP), .TAG_MODE(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .full(full), .drop(drop), .r_en(r_en), .r_data(r_data), .r_last(r_last),
    .r_chan(r_chan), .pkt_ready(pkt_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input logic [7:0] d, input logic l);
    wr_en = '0;
    wr_last = '0;
    wr_en[ch] = 1'b1;
    wr_last[ch] = l;
    wr_data[ch*DW +: DW] = d;
    tick();
    wr_en = '0;
    wr_last = '0;
  endtask

  task automatic clr();
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask

  task automatic drain(input int cycles);
    r_en = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      if (pkt_ready === 1'b1) begin
        got_d.push_back(r_data);
        got_l.push_back(r_last);
        got_c.push_back(r_chan);
      end
      tick();
    end
    r_en = 1'b0;
  endtask

  task automatic wait_ready(input int limit);
    for (int k = 0; k < limit && pkt_ready !== 1'b1; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = '0; wr_last = '0; wr_data = '0; r_en = 1'b0;
    tick(); tick();
    n_tests++;
    if ({full, drop} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags: got full=%b drop=%b want 0", full, drop);
    end
    n_tests++;
    if ({pkt_ready, r_data, r_last, r_chan} !== 12'h000) begin
      n_fail++; $display("FAIL reset_out: got rdy=%b d=%h l=%b c=%0d want 0", pkt_ready, r_data, r_last, r_chan);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] ed [4] = '{8'h02, 8'hA1, 8'hA2, 8'hA3};
    put(2, 8'hA1, 1'b0); put(2, 8'hA2, 1'b0); put(2, 8'hA3, 1'b1);
    n_tests++;
    if (pkt_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_latency: got rdy=%b want 0 at commit", pkt_ready);
    end
    tick();
    r_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if ({r_data, r_last, r_chan, pkt_ready} !== {ed[j], (j == 3), 2'd2, 1'b1}) begin
        n_fail++;
        $display("FAIL single_beat%0d: got d=%h l=%b c=%0d rdy=%b want d=%h l=%b c=2 rdy=1",
                 j, r_data, r_last, r_chan, pkt_ready, ed[j], (j == 3));
      end
      tick();
    end
    r_en = 1'b0;
    n_tests++;
    if (pkt_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_end: got rdy=%b want 0", pkt_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] ed [15] = '{8'h00, 8'h01, 8'h02, 8'h01, 8'h11, 8'h12, 8'h02, 8'h21, 8'h22,
                            8'h03, 8'h31, 8'h32, 8'h00, 8'h05, 8'h06};
    rst = 1'b1; tick(); rst = 1'b0; tick();
    wr_en = 4'hF; wr_last = 4'h0; wr_data = {8'h31, 8'h21, 8'h11, 8'h01};
    tick();
    wr_last = 4'hF; wr_data = {8'h32, 8'h22, 8'h12, 8'h02};
    tick();
    wr_en = '0; wr_last = '0;
    clr();
    r_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (pkt_ready === 1'b1) begin
        got_d.push_back(r_data); got_l.push_back(r_last); got_c.push_back(r_chan);
      end
      wr_en = '0; wr_last = '0;
      if (k == 4) begin wr_en[0] = 1'b1; wr_data[7:0] = 8'h05; end
      if (k == 5) begin wr_en[0] = 1'b1; wr_last[0] = 1'b1; wr_data[7:0] = 8'h06; end
      tick();
    end
    r_en = 1'b0; wr_en = '0; wr_last = '0;
    n_tests++;
    if (got_d.size() != 15) begin
      n_fail++; $display("FAIL rr_count: got %0d beats want 15", got_d.size());
    end
    for (int j = 0; j < 15 && j < got_d.size(); j++) begin
      n_tests++;
      if ({got_d[j], got_l[j], got_c[j]} !== {ed[j], (j % 3 == 2), (j < 12) ? 2'(j / 3) : 2'd0}) begin
        n_fail++;
        $display("FAIL rr_beat%0d: got d=%h l=%b c=%0d want d=%h l=%b c=%0d", j, got_d[j], got_l[j],
                 got_c[j], ed[j], (j % 3 == 2), (j < 12) ? j / 3 : 0);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] ed [3] = '{8'h01, 8'h55, 8'h56};
    for (int b = 0; b < 10; b++) begin
      put(1, 8'h40 + 8'(b), (b == 9));
      n_tests++;
      if ({drop, pkt_ready} !== {((b == 7) ? 4'b0010 : 4'b0000), 1'b0}) begin
        n_fail++; $display("FAIL ovf_byte%0d: got drop=%b rdy=%b want drop=%b rdy=0",
                           b, drop, pkt_ready, (b == 7) ? 4'b0010 : 4'b0000);
      end
      if (b == 6 || b == 7) begin
        n_tests++;
        if (full[1] !== (b == 6)) begin
          n_fail++; $display("FAIL ovf_full%0d: got %b want %b", b, full[1], (b == 6));
        end
      end
    end
    put(1, 8'h55, 1'b0); put(1, 8'h56, 1'b1);
    wait_ready(8);
    clr();
    drain(10);
    n_tests++;
    if (got_d.size() != 3) begin
      n_fail++; $display("FAIL ovf_count: got %0d beats want 3", got_d.size());
    end
    for (int j = 0; j < 3 && j < got_d.size(); j++) begin
      n_tests++;
      if ({got_d[j], got_l[j], got_c[j]} !== {ed[j], (j == 2), 2'd1}) begin
        n_fail++; $display("FAIL ovf_beat%0d: got d=%h l=%b c=%0d want d=%h l=%b c=1",
                           j, got_d[j], got_l[j], got_c[j], ed[j], (j == 2));
      end
    end
  endtask

  task automatic test_simul_rw();
    logic [7:0] ed [12] = '{8'h00, 8'h61, 8'h62, 8'h63, 8'h00, 8'h64, 8'h65, 8'h66,
                            8'h00, 8'h67, 8'h68, 8'h69};
    int full_seen = 0;
    clr();
    r_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (pkt_ready === 1'b1) begin
        got_d.push_back(r_data); got_l.push_back(r_last); got_c.push_back(r_chan);
      end
      if (full !== 4'b0000) full_seen++;
      wr_en = '0; wr_last = '0;
      if (k < 9) begin
        wr_en[0] = 1'b1; wr_last[0] = (k % 3 == 2); wr_data[7:0] = 8'h61 + 8'(k);
      end
      tick();
    end
    r_en = 1'b0; wr_en = '0; wr_last = '0;
    n_tests++;
    if (full_seen != 0) begin
      n_fail++; $display("FAIL simul_full: got %0d full cycles want 0", full_seen);
    end
    n_tests++;
    if (got_d.size() != 12) begin
      n_fail++; $display("FAIL simul_count: got %0d beats want 12", got_d.size());
    end
    for (int j = 0; j < 12 && j < got_d.size(); j++) begin
      n_tests++;
      if ({got_d[j], got_l[j], got_c[j]} !== {ed[j], (j % 4 == 3), 2'd0}) begin
        n_fail++; $display("FAIL simul_beat%0d: got d=%h l=%b c=%0d want d=%h l=%b c=0",
                           j, got_d[j], got_l[j], got_c[j], ed[j], (j % 4 == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ed [5] = '{8'h03, 8'h71, 8'h72, 8'h73, 8'h74};
    put(3, 8'h71, 1'b0); put(3, 8'h72, 1'b0); put(3, 8'h73, 1'b0); put(3, 8'h74, 1'b1);
    wait_ready(8);
    n_tests++;
    if (pkt_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready: got rdy=%b want 1 within 8 cycles", pkt_ready);
    end
    clr();
    drain(2);
    for (int k = 0; k < 20; k++) begin
      tick();
      n_tests++;
      if ({r_data, r_last, r_chan, pkt_ready} !== {8'h72, 1'b0, 2'd3, 1'b1}) begin
        n_fail++; $display("FAIL bp_hold%0d: got d=%h l=%b c=%0d rdy=%b want d=72 l=0 c=3 rdy=1",
                           k, r_data, r_last, r_chan, pkt_ready);
      end
    end
    drain(10);
    n_tests++;
    if (got_d.size() != 5) begin
      n_fail++; $display("FAIL bp_count: got %0d beats want 5", got_d.size());
    end
    for (int j = 0; j < 5 && j < got_d.size(); j++) begin
      n_tests++;
      if ({got_d[j], got_l[j], got_c[j]} !== {ed[j], (j == 4), 2'd3}) begin
        n_fail++; $display("FAIL bp_beat%0d: got d=%h l=%b c=%0d want d=%h l=%b c=3",
                           j, got_d[j], got_l[j], got_c[j], ed[j], (j == 4));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    put(2, 8'h81, 1'b0); put(2, 8'h82, 1'b0); put(2, 8'h83, 1'b1);
    wait_ready(8);
    r_en = 1'b1; tick(); r_en = 1'b0;
    n_tests++;
    if ({r_data, pkt_ready} !== {8'h81, 1'b1}) begin
      n_fail++; $display("FAIL rmr_pre: got d=%h rdy=%b want d=81 rdy=1", r_data, pkt_ready);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({full, drop, pkt_ready, r_data, r_last, r_chan} !== 20'h00000) begin
      n_fail++; $display("FAIL rmr_async: got full=%b drop=%b rdy=%b d=%h l=%b c=%0d want 0",
                         full, drop, pkt_ready, r_data, r_last, r_chan);
    end
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if ({pkt_ready, drop} !== 5'b00000) begin
        n_fail++; $display("FAIL rmr_idle%0d: got rdy=%b drop=%b want 0", k, pkt_ready, drop);
      end
    end
    put(1, 8'h99, 1'b1);
    wait_ready(8);
    clr();
    drain(12);
    n_tests++;
    if (got_d.size() != 2) begin
      n_fail++; $display("FAIL rmr_count: got %0d beats want 2", got_d.size());
    end
    if (got_d.size() == 2) begin
      n_tests++;
      if ({got_d[0], got_l[0], got_c[0], got_d[1], got_l[1], got_c[1]} !==
          {8'h01, 1'b0, 2'd1, 8'h99, 1'b1, 2'd1}) begin
        n_fail++; $display("FAIL rmr_data: got %h/%b/%0d %h/%b/%0d want 01/0/1 99/1/1",
                           got_d[0], got_l[0], got_c[0], got_d[1], got_l[1], got_c[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_simul_rw();
    test_backpressure();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_packet_storage.md
Name: multi_packet_storage

Overview:
- Parametrised successor to the single-channel Ethernet packet store.
- Buffers byte packets from NUM_CH independent Ethernet receive channels, each in its own packet FIFO.
- Presents one show-ahead byte stream to the USB transceiver, arbitrating round-robin at whole-packet granularity.
- Adds three things the single-channel store lacks: multiple channels, an optional channel-tag byte ahead of each packet, and drop-on-overflow with write-pointer rollback.

Parameters:
- NUM_CH, 4: number of input channels (2..8).
- DATA_W, 8: byte width.
- DEPTH, 64: entries per channel FIFO; must be a power of two.
- TAG_MODE, 1: when 1, a tag byte {(DATA_W-CH_W) zeros, channel index} is emitted before each packet; when 0, no tag.
- CH_W, $clog2(NUM_CH): derived; not to be overridden.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  NUM_CH  per-channel byte write strobe.
- wr_data  input  NUM_CH*DATA_W  per-channel byte; channel i occupies bits [i*DATA_W +: DATA_W].
- wr_last  input  NUM_CH  marks the final byte of a packet; qualified by wr_en.
- full  output  NUM_CH  channel FIFO full, registered.
- drop  output  NUM_CH  one-cycle pulse when a packet is discarded.
- r_en  input  1  transceiver pops the current output byte.
- r_data  output  DATA_W  current output byte, show-ahead.
- r_last  output  1  r_data is the final byte of the packet.
- r_chan  output  CH_W  channel index of the packet being read.
- pkt_ready  output  1  r_data/r_last/r_chan are valid and may be popped.

Behaviour:
- Reset (async assert, sync release): every pointer, packet counter and flag cleared. Outputs: full=0, drop=0, pkt_ready=0, r_data=0, r_last=0, r_chan=0. Arbiter enters IDLE with its round-robin pointer at channel 0.
- Channel storage: DEPTH x (DATA_W+1) entries, holding the data byte plus the last flag.
- Channel pointers:
  - wptr advances on each accepted write.
  - cptr (committed) := wptr+1 when the accepted byte has wr_last=1.
  - rptr advances on data pops.
  - All pointers wrap modulo DEPTH; an extra MSB distinguishes full from empty.
- pkt_cnt per channel = committed, unread packets. Increments on commit, decrements when the last byte is popped. Simultaneous increment and decrement leaves it unchanged.
- Overflow: a write while full (or while wptr+1 == rptr):
  - byte is discarded;
  - wptr rolls back to cptr next cycle;
  - drop[i] pulses for one cycle;
  - the channel enters DISCARD and ignores writes up to and including the next wr_last byte, then returns to normal.
- Single-byte packet (wr_en with wr_last) arriving while full is dropped the same way and does not enter DISCARD.
- Arbiter FSM:
  - IDLE: scan from rr_ptr for the first channel with pkt_cnt>0. On a hit, latch sel and r_chan and go to TAG (TAG_MODE=1) or DATA (TAG_MODE=0). pkt_ready rises the cycle after the hit; arbitration latency is 1 cycle.
  - TAG: r_data = tag byte, r_last=0, pkt_ready=1. On r_en go to DATA; the FIFO is not popped.
  - DATA: r_data/r_last come from sel's FIFO head and pkt_ready=1. Each r_en pops one byte. When r_en pops a byte with r_last=1, pkt_ready goes low the next cycle, rr_ptr := sel+1 (mod NUM_CH), and the FSM returns to IDLE.
- A packet is never interleaved with another channel's packet.
- r_en while pkt_ready=0 is ignored; no pointer moves.
- A channel may be written and read in the same cycle; full is computed from post-update pointers.
- Packets longer than DEPTH-1 bytes can never commit and are always dropped.
- rst mid-packet: all buffered data is lost, with no drop pulse.

Test Plan:
- Single channel, TAG_MODE=1: write 3 bytes 0xA1,0xA2,0xA3(last) on ch2, pop continuously -> pkt_ready one cycle after commit; stream is 0x02,0xA1,0xA2,0xA3 with r_last only on 0xA3; r_chan=2 throughout; pkt_ready low the cycle after the final pop.
- Round-robin: one 2-byte packet committed on each of ch0..ch3 simultaneously, pop continuously -> packets emerge in order ch0,ch1,ch2,ch3; a new ch0 packet committed during the ch1 read is served after ch3.
- Overflow: DEPTH=8; write a 10-byte packet on ch1 -> drop[1] pulses once when the 8th byte is written (wptr+1 == rptr, 7 bytes stored); pkt_cnt stays 0; bytes 9-10 are ignored in DISCARD; a following 2-byte packet is stored and read intact.
- Simultaneous write/read: while ch0 is being read, keep ch0 writes flowing at one byte per cycle -> no spurious full, no data corruption, pkt_cnt correct at every commit.
- Backpressure: hold r_en=0 for 20 cycles mid-packet -> r_data/r_last/r_chan stay stable; the sequence resumes with no lost or duplicated bytes.
- Reset mid-read: assert rst while in DATA -> all outputs are 0 in the same cycle; after release, pkt_ready=0 until a new packet commits.
